// File: rtl/lstm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lstm_ctrl_pkg
// Purpose  : Shared definitions for the LSTM cell sequencer: default sizes,
//            3-bit FSM state encoding and the cycles-per-unit formula.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package lstm_ctrl_pkg;

  // Default sizes
  localparam int DEF_N_IN    = 8;
  localparam int DEF_N_HID   = 8;
  localparam int DEF_N_STEP  = 16;
  localparam int DEF_ACT_LAT = 2;
  localparam int DEF_AW      = 16;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_ACCX = 3'd2;
  localparam logic [2:0] ST_ACCH = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    CLR  = ST_CLR,
    ACCX = ST_ACCX,
    ACCH = ST_ACCH,
    WAIT = ST_WAIT,
    WB   = ST_WB,
    DONE = ST_DONE
  } state_t;

  // Cycles spent on one hidden unit: clear + x terms + h terms + activation
  // latency + write-back.
  function automatic int cycles_per_unit(input int n_in, input int n_hid,
                                         input int act_lat);
    return n_in + n_hid + act_lat + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_loop_cnt.sv
`default_nettype none
// ============================================================================
// Module   : lstm_loop_cnt
// Purpose  : Loop counter with enable, sync clear, run-time terminal value
//            and a running offset (count * STRIDE) kept without a multiplier.
// Ports    : clk, rst      - clock, sync active-high reset
//            clr           - sync clear of count and offset
//            en            - advance; wraps to 0 when the terminal value is hit
//            limit [W]     - terminal (last) count value
//            count [W]     - current index
//            off   [W]     - count * STRIDE
//            last          - count == limit
// Revision : 1.0 - initial release
// ============================================================================
module lstm_loop_cnt
  import lstm_ctrl_pkg::*;
#(
  parameter int W      = DEF_AW,
  parameter int STRIDE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic [W-1:0] off,
  output logic         last
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] INC = W'(STRIDE);

  assign last = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      off   <= '0;
    end else if (en) begin
      if (last) begin
        count <= '0;
        off   <= '0;
      end else begin
        count <= count + ONE;
        off   <= off + INC;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lstm_seq_ctrl
// Purpose  : Sequencer for a time-multiplexed LSTM cell. Per timestep and
//            hidden unit: clear accumulators, stream N_IN x terms and N_HID
//            h terms, wait ACT_LAT cycles, write c/h into the banked state.
// Ports    : clk, rst, i_start          - clock, sync reset, start pulse
//            o_busy, o_done             - status
//            o_clr, o_acc_x, o_acc_h    - cell strobes
//            o_x/w/u/b_addr, o_h/c_raddr- read addresses
//            o_rd_bank, o_wr_bank       - state bank select
//            o_prev_zero                - zero previous state (step 0)
//            o_we, o_waddr              - state write strobe/address
//            o_step, o_unit             - current indices
// Revision : 1.0 - initial release
// ============================================================================
module lstm_seq_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int N_HID   = DEF_N_HID,
  parameter int N_STEP  = DEF_N_STEP,
  parameter int ACT_LAT = DEF_ACT_LAT,
  parameter int AW      = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_clr,
  output logic          o_acc_x,
  output logic          o_acc_h,
  output logic [AW-1:0] o_x_addr,
  output logic [AW-1:0] o_w_addr,
  output logic [AW-1:0] o_u_addr,
  output logic [AW-1:0] o_b_addr,
  output logic [AW-1:0] o_h_raddr,
  output logic [AW-1:0] o_c_raddr,
  output logic          o_rd_bank,
  output logic          o_wr_bank,
  output logic          o_prev_zero,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [AW-1:0] o_step,
  output logic [AW-1:0] o_unit
);

  localparam logic [AW-1:0] K_LAST_X  = AW'(N_IN - 1);
  localparam logic [AW-1:0] K_LAST_H  = AW'(N_HID - 1);
  localparam logic [AW-1:0] UNIT_LAST = AW'(N_HID - 1);
  localparam logic [AW-1:0] STEP_LAST = AW'(N_STEP - 1);
  localparam logic [AW-1:0] HID_INC   = AW'(N_HID);
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] WAIT_INIT = (ACT_LAT > 0) ? AW'(ACT_LAT - 1) : '0;

  state_t        state, state_nxt;
  logic [AW-1:0] k, k_off, k_limit;
  logic [AW-1:0] unit, unit_off;
  logic [AW-1:0] step, step_off;
  logic [AW-1:0] u_base;
  logic [AW-1:0] wait_cnt;
  logic          k_last, unit_last, step_last;
  logic          k_en, unit_en, step_en, cnt_clr;
  logic          rd_bank, busy;

  // k serves both the x and h loops; only its terminal value changes.
  assign k_limit = (state == ACCH) ? K_LAST_H : K_LAST_X;

  lstm_loop_cnt #(.W(AW), .STRIDE(1)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(k_en), .limit(k_limit),
    .count(k), .off(k_off), .last(k_last)
  );

  // unit offset = unit*N_IN (W base address)
  lstm_loop_cnt #(.W(AW), .STRIDE(N_IN)) u_unit_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(unit_en), .limit(UNIT_LAST),
    .count(unit), .off(unit_off), .last(unit_last)
  );

  // step offset = step*N_IN (x base address)
  lstm_loop_cnt #(.W(AW), .STRIDE(N_IN)) u_step_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(step_en), .limit(STEP_LAST),
    .count(step), .off(step_off), .last(step_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    k_en      = 1'b0;
    unit_en   = 1'b0;
    step_en   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (i_start) state_nxt = CLR;
      end
      CLR:  state_nxt = ACCX;
      ACCX: begin
        k_en = 1'b1;
        if (k_last) state_nxt = ACCH;
      end
      ACCH: begin
        k_en = 1'b1;
        if (k_last) state_nxt = (ACT_LAT > 0) ? WAIT : WB;
      end
      WAIT: if (wait_cnt == '0) state_nxt = WB;
      WB: begin
        if (!unit_last) begin
          unit_en   = 1'b1;
          state_nxt = CLR;
        end else if (!step_last) begin
          unit_en   = 1'b1;  // wraps unit back to 0
          step_en   = 1'b1;
          state_nxt = CLR;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Activation wait: reloaded every ACCH cycle so it is primed on entry.
  always_ff @(posedge clk) begin
    if (rst)                                  wait_cnt <= '0;
    else if (state == ACCH)                   wait_cnt <= WAIT_INIT;
    else if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - ONE;
  end

  // U base = unit*N_HID, tracked alongside the unit counter.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)  u_base <= '0;
    else if (unit_en)    u_base <= unit_last ? '0 : u_base + HID_INC;
  end

  // Banks swap at every step boundary; a new sequence reads bank 0.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) rd_bank <= 1'b0;
    else if (step_en)   rd_bank <= ~rd_bank;
  end

  assign busy        = (state != IDLE) && (state != DONE);
  assign o_busy      = busy;
  assign o_done      = (state == DONE);
  assign o_clr       = (state == CLR);
  assign o_acc_x     = (state == ACCX);
  assign o_acc_h     = (state == ACCH);
  assign o_we        = (state == WB);
  assign o_x_addr    = step_off + k_off;
  assign o_w_addr    = unit_off + k_off;
  assign o_u_addr    = u_base + k_off;
  assign o_b_addr    = unit;
  assign o_h_raddr   = k;
  assign o_c_raddr   = unit;
  assign o_rd_bank   = rd_bank;
  assign o_wr_bank   = ~rd_bank;
  assign o_prev_zero = busy && (step == '0);
  assign o_waddr     = unit;
  assign o_step      = step;
  assign o_unit      = unit;

endmodule
`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lstm_seq_ctrl
// Purpose  : Self-checking bench for lstm_seq_ctrl. Instance A uses
//            N_IN=N_HID=N_STEP=ACT_LAT=2, instance B uses 1/1/1/0.
//            Expected outputs come from a cycle-index reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lstm_seq_ctrl;

  localparam int AW = 16;

  typedef struct packed {
    logic busy, done, clr, acc_x, acc_h, we, prev_zero, rd_bank, wr_bank;
    logic [AW-1:0] waddr, x_addr, w_addr, u_addr, h_raddr, b_addr, c_raddr,
                   step, unit;
  } obs_t;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } vec_t;

  localparam int S_BUSY = 0, S_DONE = 1, S_CLR = 2, S_AX = 3, S_AH = 4,
                 S_WE = 5, S_PZ = 6, S_RB = 7, S_WB = 8, S_WADDR = 9,
                 S_X = 10, S_W = 11, S_U = 12, S_H = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, rst_b, start_b;
  obs_t obs_a, obs_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic a_busy, a_done, a_clr, a_ax, a_ah, a_rb, a_wb, a_pz, a_we;
  logic [AW-1:0] a_x, a_w, a_u, a_b, a_h, a_c, a_waddr, a_step, a_unit;
  logic b_busy, b_done, b_clr, b_ax, b_ah, b_rb, b_wb, b_pz, b_we;
  logic [AW-1:0] b_x, b_w, b_u, b_b, b_h, b_c, b_waddr, b_step, b_unit;

  lstm_seq_ctrl #(.N_IN(2), .N_HID(2), .N_STEP(2), .ACT_LAT(2), .AW(AW)) dut_a (
    .clk(clk), .rst(rst_a), .i_start(start_a), .o_busy(a_busy), .o_done(a_done),
    .o_clr(a_clr), .o_acc_x(a_ax), .o_acc_h(a_ah), .o_x_addr(a_x), .o_w_addr(a_w),
    .o_u_addr(a_u), .o_b_addr(a_b), .o_h_raddr(a_h), .o_c_raddr(a_c),
    .o_rd_bank(a_rb), .o_wr_bank(a_wb), .o_prev_zero(a_pz), .o_we(a_we),
    .o_waddr(a_waddr), .o_step(a_step), .o_unit(a_unit)
  );

  lstm_seq_ctrl #(.N_IN(1), .N_HID(1), .N_STEP(1), .ACT_LAT(0), .AW(AW)) dut_b (
    .clk(clk), .rst(rst_b), .i_start(start_b), .o_busy(b_busy), .o_done(b_done),
    .o_clr(b_clr), .o_acc_x(b_ax), .o_acc_h(b_ah), .o_x_addr(b_x), .o_w_addr(b_w),
    .o_u_addr(b_u), .o_b_addr(b_b), .o_h_raddr(b_h), .o_c_raddr(b_c),
    .o_rd_bank(b_rb), .o_wr_bank(b_wb), .o_prev_zero(b_pz), .o_we(b_we),
    .o_waddr(b_waddr), .o_step(b_step), .o_unit(b_unit)
  );

  assign obs_a = {a_busy, a_done, a_clr, a_ax, a_ah, a_we, a_pz, a_rb, a_wb,
                  a_waddr, a_x, a_w, a_u, a_h, a_b, a_c, a_step, a_unit};
  assign obs_b = {b_busy, b_done, b_clr, b_ax, b_ah, b_we, b_pz, b_rb, b_wb,
                  b_waddr, b_x, b_w, b_u, b_h, b_b, b_c, b_step, b_unit};

  // Reference: d = cycles since the start was sampled (0 or beyond the end =
  // idle). Everything follows from d by plain division into step/unit/phase.
  function automatic obs_t exp_at(int d, int ni, int nh, int ns, int al);
    obs_t e;
    int t, len, idx, ph, st, un, k;
    e   = '0;
    t   = ni + nh + al + 2;
    len = ns * nh * t + 1;
    if (d <= 0 || d > len) begin
      e.wr_bank = 1'b1;
      return e;
    end
    if (d == len) begin
      e.done = 1'b1;
      return e;
    end
    idx = (d - 1) / t;
    ph  = (d - 1) % t;
    st  = idx / nh;
    un  = idx % nh;
    e.busy      = 1'b1;
    e.step      = AW'(st);
    e.unit      = AW'(un);
    e.b_addr    = AW'(un);
    e.c_raddr   = AW'(un);
    e.rd_bank   = (st % 2) == 1;
    e.wr_bank   = (st % 2) == 0;
    e.prev_zero = (st == 0);
    if (ph == 0) begin
      e.clr = 1'b1;
    end else if (ph <= ni) begin
      k        = ph - 1;
      e.acc_x  = 1'b1;
      e.x_addr = AW'(st * ni + k);
      e.w_addr = AW'(un * ni + k);
    end else if (ph <= ni + nh) begin
      k         = ph - 1 - ni;
      e.acc_h   = 1'b1;
      e.u_addr  = AW'(un * nh + k);
      e.h_raddr = AW'(k);
    end else if (ph == t - 1) begin
      e.we    = 1'b1;
      e.waddr = AW'(un);
    end
    return e;
  endfunction

  // Addresses are only defined while their strobe is active.
  function automatic bit obs_ok(obs_t a, obs_t e);
    bit ok;
    ok = (a.busy == e.busy) && (a.done == e.done) && (a.clr == e.clr) &&
         (a.acc_x == e.acc_x) && (a.acc_h == e.acc_h) && (a.we == e.we) &&
         (a.prev_zero == e.prev_zero);
    if (e.busy)
      ok = ok && (a.rd_bank == e.rd_bank) && (a.wr_bank == e.wr_bank) &&
           (a.step == e.step) && (a.unit == e.unit) &&
           (a.b_addr == e.b_addr) && (a.c_raddr == e.c_raddr);
    if (e.acc_x) ok = ok && (a.x_addr == e.x_addr) && (a.w_addr == e.w_addr);
    if (e.acc_h) ok = ok && (a.u_addr == e.u_addr) && (a.h_raddr == e.h_raddr);
    if (e.we)    ok = ok && (a.waddr == e.waddr);
    return ok;
  endfunction

  task automatic check_obs(string name, int c, obs_t a, obs_t e);
    n_cmp++;
    if (!obs_ok(a, e)) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, a, e);
    end
  endtask

  task automatic check_exact(string name, obs_t a, obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, a, e);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int pick(obs_t o, int s);
    case (s)
      S_BUSY:  return int'(o.busy);
      S_DONE:  return int'(o.done);
      S_CLR:   return int'(o.clr);
      S_AX:    return int'(o.acc_x);
      S_AH:    return int'(o.acc_h);
      S_WE:    return int'(o.we);
      S_PZ:    return int'(o.prev_zero);
      S_RB:    return int'(o.rd_bank);
      S_WB:    return int'(o.wr_bank);
      S_WADDR: return int'(o.waddr);
      S_X:     return int'(o.x_addr);
      S_W:     return int'(o.w_addr);
      S_U:     return int'(o.u_addr);
      default: return int'(o.h_raddr);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  obs_t rec_a [0:63];
  obs_t rec_b [0:63];
  vec_t tbl [$];
  string sig_name [0:13] = '{"busy", "done", "clr", "acc_x", "acc_h", "we",
                             "prev_zero", "rd_bank", "wr_bank", "waddr",
                             "x_addr", "w_addr", "u_addr", "h_raddr"};

  initial begin
    obs_t idle_exp;
    int   done_cnt, we_cnt, done_cyc;
    bit   run [2];
    int   d [2];
    int   len [2];

    idle_exp         = '0;
    idle_exp.wr_bank = 1'b1;

    // Test-plan checkpoints for instance A, start at cycle 0.
    tbl = '{'{0, S_BUSY, 0}, '{1, S_BUSY, 1}, '{1, S_CLR, 1}, '{32, S_BUSY, 1},
            '{33, S_BUSY, 0}, '{32, S_DONE, 0}, '{33, S_DONE, 1}, '{34, S_DONE, 0},
            '{7, S_WE, 0}, '{8, S_WE, 1}, '{8, S_WADDR, 0}, '{9, S_WE, 0},
            '{16, S_WE, 1}, '{16, S_WADDR, 1}, '{24, S_WE, 1}, '{24, S_WADDR, 0},
            '{32, S_WE, 1}, '{32, S_WADDR, 1}, '{9, S_CLR, 1},
            '{26, S_AX, 1}, '{26, S_X, 2}, '{26, S_W, 2},
            '{27, S_AX, 1}, '{27, S_X, 3}, '{27, S_W, 3}, '{28, S_AX, 0},
            '{28, S_AH, 1}, '{28, S_U, 2}, '{28, S_H, 0},
            '{29, S_AH, 1}, '{29, S_U, 3}, '{29, S_H, 1}, '{30, S_AH, 0},
            '{25, S_PZ, 0}, '{29, S_PZ, 0}, '{32, S_PZ, 0},
            '{5, S_PZ, 1}, '{5, S_RB, 0}, '{5, S_WB, 1},
            '{20, S_PZ, 0}, '{20, S_RB, 1}, '{20, S_WB, 0}};

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tick(); tick();
    check_exact("reset_a", obs_a, idle_exp);
    check_exact("reset_b", obs_b, idle_exp);
    rst_a = 1'b0; rst_b = 1'b0;

    // Run 1: start at 0, ignored re-pulse at 10; B starts at 0 as well.
    done_cnt = 0; we_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      start_a  = (c == 0) || (c == 10);
      start_b  = (c == 0);
      rec_a[c] = obs_a;
      rec_b[c] = obs_b;
      done_cnt += int'(obs_a.done);
      we_cnt   += int'(obs_a.we);
      tick();
    end
    start_a = 1'b0; start_b = 1'b0;

    foreach (tbl[i])
      check_val($sformatf("plan_%s@%0d", sig_name[tbl[i].sig], tbl[i].cyc),
                pick(rec_a[tbl[i].cyc], tbl[i].sig), tbl[i].val);
    check_val("run1_done_count", done_cnt, 1);
    check_val("run1_we_count", we_cnt, 4);
    for (int c = 0; c <= 40; c++) check_obs("run1_model_a", c, rec_a[c], exp_at(c, 2, 2, 2, 2));
    for (int c = 0; c <= 8; c++)  check_obs("degen_model_b", c, rec_b[c], exp_at(c, 1, 1, 1, 0));
    check_val("degen_done_at5", int'(rec_b[5].done), 1);
    check_val("degen_acch_at3", int'(rec_b[3].acc_h), 1);
    check_val("degen_we_at4", int'(rec_b[4].we), 1);

    // Run 2: abort with rst at 12, restart at 15.
    done_cnt = 0; done_cyc = -1;
    for (int c = 0; c <= 55; c++) begin
      start_a  = (c == 0) || (c == 15);
      rst_a    = (c == 12);
      rec_a[c] = obs_a;
      if (obs_a.done) begin
        done_cnt++;
        done_cyc = c;
      end
      tick();
    end
    start_a = 1'b0; rst_a = 1'b0;
    check_exact("abort_idle@13", rec_a[13], idle_exp);
    check_val("abort_done_count", done_cnt, 1);
    check_val("abort_done_cycle", done_cyc, 48);
    for (int c = 0; c <= 55; c++)
      check_obs("run2_model_a", c, rec_a[c],
                (c <= 12) ? exp_at(c, 2, 2, 2, 2) :
                (c <= 15) ? exp_at(0, 2, 2, 2, 2) : exp_at(c - 15, 2, 2, 2, 2));

    // Randomised starts and resets on both instances against the model.
    run[0] = 1'b0; run[1] = 1'b0; d[0] = 0; d[1] = 0;
    len[0] = 2 * 2 * 8 + 1;
    len[1] = 1 * 1 * 4 + 1;
    for (int c = 0; c < 800; c++) begin
      start_a = ($urandom_range(0, 9) == 0);
      rst_a   = ($urandom_range(0, 199) == 0);
      start_b = ($urandom_range(0, 5) == 0);
      rst_b   = ($urandom_range(0, 99) == 0);
      check_obs("rand_a", c, obs_a, exp_at(run[0] ? d[0] : 0, 2, 2, 2, 2));
      check_obs("rand_b", c, obs_b, exp_at(run[1] ? d[1] : 0, 1, 1, 1, 0));
      for (int u = 0; u < 2; u++) begin
        logic r, s;
        r = (u == 0) ? rst_a : rst_b;
        s = (u == 0) ? start_a : start_b;
        if (r) run[u] = 1'b0;
        else if (!run[u]) begin
          if (s) begin
            run[u] = 1'b1;
            d[u]   = 1;
          end
        end else if (d[u] == len[u]) run[u] = 1'b0;
        else d[u]++;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
